// File: rtl/jt900h_muldiv.sv
// Iterative W-bit divider (restoring, 2W/W) with optional shift-and-add multiplier.
// Define JT900H_MULDIV_MUL_EN to build the multiply datapath; otherwise multiply starts are ignored.
module jt900h_muldiv #(
    parameter int unsigned W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic           start,
    input  logic           mode,
    input  logic           sign,
    input  logic [2*W-1:0] op0,
    input  logic [W-1:0]   op1,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   quot,
    output logic [W-1:0]   rem,
    output logic [2*W-1:0] prod,
    output logic           v,
    output logic           dz
);

    localparam int unsigned CW = $clog2(W) + 1;
    localparam logic [W-1:0] HalfRange = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StFix, StEnd} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           sign_q;
    logic           neg_q;
    logic           rneg_q;
    logic           ovf_q;
    logic           dz_q;
    logic           v_q;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   lo_q;
    logic [W-1:0]   dvs_q;
    logic [W-1:0]   op0lo_q;

    logic [2*W-1:0] a_mag;
    logic [W-1:0]   b_mag;
    logic [W:0]     shifted;
    logic [W:0]     diff;
    logic           ge;
    logic           q_ovf;
    logic           mode_ok;

    assign a_mag = (sign && op0[2*W-1]) ? -op0 : op0;
    assign b_mag = (sign && op1[W-1]) ? -op1 : op1;

    // Restoring step: with acc < divisor the borrow bit alone decides the quotient bit.
    assign shifted = {acc_q, lo_q[W-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign ge      = !diff[W];

    // Quotient magnitude that does not fit the signed result range.
    assign q_ovf = sign_q && (neg_q ? (lo_q > HalfRange) : lo_q[W-1]);

`ifdef JT900H_MULDIV_MUL_EN
    logic           mode_q;
    logic [W-1:0]   m_mag;
    logic [W:0]     mul_sum;

    assign mode_ok = 1'b1;
    assign m_mag   = (sign && op0[W-1]) ? -op0[W-1:0] : op0[W-1:0];
    assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, dvs_q} : {(W+1){1'b0}});
`else
    assign mode_ok = !mode;
    assign prod    = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            quot    <= '0;
            rem     <= '0;
            v       <= 1'b0;
            dz      <= 1'b0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            v_q     <= 1'b0;
            acc_q   <= '0;
            lo_q    <= '0;
            dvs_q   <= '0;
            op0lo_q <= '0;
`ifdef JT900H_MULDIV_MUL_EN
            mode_q  <= 1'b0;
            prod    <= '0;
`endif
        end else if (cen) begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A start seen alongside the done pulse belongs to the finished operation.
                    if (start && !done && mode_ok) begin
                        state_q <= StRun;
                        busy    <= 1'b1;
                        cnt_q   <= '0;
                        sign_q  <= sign;
                        v_q     <= 1'b0;
                        op0lo_q <= op0[W-1:0];
`ifdef JT900H_MULDIV_MUL_EN
                        mode_q  <= mode;
                        if (mode) begin
                            acc_q  <= '0;
                            lo_q   <= b_mag;
                            dvs_q  <= m_mag;
                            neg_q  <= sign && (op0[W-1] ^ op1[W-1]);
                            rneg_q <= 1'b0;
                            ovf_q  <= 1'b0;
                            dz_q   <= 1'b0;
                        end else begin
`endif
                            acc_q  <= a_mag[2*W-1:W];
                            lo_q   <= a_mag[W-1:0];
                            dvs_q  <= b_mag;
                            neg_q  <= sign && (op0[2*W-1] ^ op1[W-1]);
                            rneg_q <= sign && op0[2*W-1];
                            ovf_q  <= a_mag[2*W-1:W] >= b_mag;
                            dz_q   <= (op1 == '0);
`ifdef JT900H_MULDIV_MUL_EN
                        end
`endif
                    end
                end
                StRun: begin
                    if (dz_q) begin
                        state_q <= StEnd;
                        v_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(W - 1)) begin
                            state_q <= StFix;
                        end
`ifdef JT900H_MULDIV_MUL_EN
                        if (mode_q) begin
                            acc_q <= mul_sum[W:1];
                            lo_q  <= {mul_sum[0], lo_q[W-1:1]};
                        end else begin
`endif
                            acc_q <= ge ? diff[W-1:0] : shifted[W-1:0];
                            lo_q  <= {lo_q[W-2:0], ge};
`ifdef JT900H_MULDIV_MUL_EN
                        end
`endif
                    end
                end
                StFix: begin
                    state_q <= StEnd;
`ifdef JT900H_MULDIV_MUL_EN
                    if (mode_q) begin
                        if (neg_q) begin
                            {acc_q, lo_q} <= -{acc_q, lo_q};
                        end
                    end else begin
`endif
                        lo_q  <= neg_q ? -lo_q : lo_q;
                        acc_q <= rneg_q ? -acc_q : acc_q;
                        v_q   <= ovf_q || q_ovf;
`ifdef JT900H_MULDIV_MUL_EN
                    end
`endif
                end
                StEnd: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b1;
`ifdef JT900H_MULDIV_MUL_EN
                    if (mode_q) begin
                        prod <= {acc_q, lo_q};
                        v    <= 1'b0;
                        dz   <= 1'b0;
                    end else begin
`endif
                        quot <= v_q ? {W{1'b1}} : lo_q;
                        rem  <= v_q ? op0lo_q : acc_q;
                        v    <= v_q;
                        dz   <= dz_q;
`ifdef JT900H_MULDIV_MUL_EN
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt900h_muldiv.sv
// Bench for jt900h_muldiv at W=16: arithmetic reference model checked every cycle plus literal checks.
module tb_jt900h_muldiv;

    localparam int W = 16;
`ifdef JT900H_MULDIV_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cen = 1'b1;
    logic           start = 1'b0;
    logic           mode = 1'b0;
    logic           sign = 1'b0;
    logic [2*W-1:0] op0 = '0;
    logic [W-1:0]   op1 = '0;
    logic           busy, done, v, dz;
    logic [W-1:0]   quot, rem;
    logic [2*W-1:0] prod;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;
    int n;

    always #5 clk = ~clk;

    jt900h_muldiv #(.W(W)) dut (
        .clk(clk), .rst(rst), .cen(cen), .start(start), .mode(mode), .sign(sign),
        .op0(op0), .op1(op1), .busy(busy), .done(done), .quot(quot), .rem(rem),
        .prod(prod), .v(v), .dz(dz)
    );

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference model: results from plain integer arithmetic, timing from a cen-edge countdown.
    logic           m_busy = 0, m_done = 0, m_v = 0, m_dz = 0;
    logic [W-1:0]   m_quot = '0, m_rem = '0;
    logic [2*W-1:0] m_prod = '0;
    logic           p_mul, p_v, p_dz;
    logic [W-1:0]   p_quot, p_rem;
    logic [2*W-1:0] p_prod;
    int             m_left = 0;
    bit             was_done;

    task automatic compute(input logic [2*W-1:0] a0, input logic [W-1:0] b0,
                           input logic md, input logic sg);
        longint a, b, ma, q, r, lim;
        logic [W-1:0] lo;
        lo  = a0[W-1:0];
        a   = sg ? longint'($signed(a0)) : longint'(a0);
        b   = sg ? longint'($signed(b0)) : longint'(b0);
        lim = longint'(1) << (W - 1);
        p_mul = md;
        if (md) begin
            ma = sg ? longint'($signed(lo)) : longint'(lo);
            p_prod = (2*W)'(ma * b);
        end else if (b == 0) begin
            p_dz = 1; p_v = 1; p_quot = '1; p_rem = lo;
        end else begin
            q = a / b;
            r = a % b;
            p_dz = 0;
            p_v = sg ? (q > lim - 1 || q < -lim) : (a0[2*W-1:W] >= b0);
            p_quot = p_v ? {W{1'b1}} : W'(q);
            p_rem  = p_v ? lo : W'(r);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 0; m_done = 0; m_v = 0; m_dz = 0;
            m_quot = '0; m_rem = '0; m_prod = '0; m_left = 0;
        end else if (cen) begin
            was_done = m_done;
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    if (p_mul) begin
                        m_prod = p_prod; m_v = 0; m_dz = 0;
                    end else begin
                        m_quot = p_quot; m_rem = p_rem; m_v = p_v; m_dz = p_dz;
                    end
                end
            end else if (start && !was_done && (MulEn || !mode)) begin
                compute(op0, op1, mode, sign);
                m_left = (!mode && op1 == '0) ? 2 : W + 2;
                m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            cmp("busy", 64'(busy), 64'(m_busy));
            cmp("done", 64'(done), 64'(m_done));
            cmp("quot", 64'(quot), 64'(m_quot));
            cmp("rem",  64'(rem),  64'(m_rem));
            cmp("prod", 64'(prod), 64'(m_prod));
            cmp("v",    64'(v),    64'(m_v));
            cmp("dz",   64'(dz),   64'(m_dz));
        end
    end

    // Issues one start and counts clocks from the start edge to the edge that raises done.
    task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b, input logic md,
                          input logic sg, input bit tog, output int cnt);
        @(posedge clk); #1;
        op0 = a; op1 = b; mode = md; sign = sg; start = 1'b1; cen = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (tog) cen = 1'b0;
        cnt = 0;
        while (cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
            if (done) break;
            if (tog) cen = ~cen;
        end
        cen = 1'b1;
    endtask

    task automatic chk_div(input string nm, input logic [W-1:0] q, input logic [W-1:0] r,
                           input logic ev, input logic edz);
        cmp({nm, " quot"}, 64'(quot), 64'(q));
        cmp({nm, " rem"},  64'(rem),  64'(r));
        cmp({nm, " v"},    64'(v),    64'(ev));
        cmp({nm, " dz"},   64'(dz),   64'(edz));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        checking = 1'b1;
        cmp("reset busy", 64'(busy), 64'(0));
        cmp("reset done", 64'(done), 64'(0));
        cmp("reset quot", 64'(quot), 64'(0));
        cmp("reset prod", 64'(prod), 64'(0));

        run_op(32'h000186A0, 16'h012C, 1'b0, 1'b0, 1'b0, n);
        cmp("udiv latency", 64'(n), 64'(18));
        chk_div("udiv", 16'h014D, 16'h0064, 1'b0, 1'b0);

        // Start held while done is high must be dropped.
        start = 1'b1; op0 = 32'h00000009; op1 = 16'h0002;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        cmp("start with done ignored", 64'(busy), 64'(0));

        run_op(32'hFFFFFFF9, 16'h0002, 1'b0, 1'b1, 1'b0, n);
        cmp("sdiv latency", 64'(n), 64'(18));
        chk_div("sdiv -7/2", 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);

        run_op(32'h00000007, 16'hFFFE, 1'b0, 1'b1, 1'b0, n);
        chk_div("sdiv 7/-2", 16'hFFFD, 16'h0001, 1'b0, 1'b0);

        run_op(32'h00001234, 16'h0000, 1'b0, 1'b0, 1'b0, n);
        cmp("dz latency", 64'(n), 64'(2));
        chk_div("div0", 16'hFFFF, 16'h1234, 1'b1, 1'b1);

        run_op(32'h00010000, 16'h0001, 1'b0, 1'b0, 1'b0, n);
        chk_div("udiv ovf", 16'hFFFF, 16'h0000, 1'b1, 1'b0);

        run_op(32'h0000FFFF, 16'h0001, 1'b0, 1'b0, 1'b0, n);
        chk_div("udiv max", 16'hFFFF, 16'h0000, 1'b0, 1'b0);

        run_op(32'h00008000, 16'h0001, 1'b0, 1'b1, 1'b0, n);
        chk_div("sdiv ovf", 16'hFFFF, 16'h8000, 1'b1, 1'b0);

        run_op(32'hFFFF8000, 16'h0001, 1'b0, 1'b1, 1'b0, n);
        chk_div("sdiv min", 16'h8000, 16'h0000, 1'b0, 1'b0);

`ifdef JT900H_MULDIV_MUL_EN
        run_op(32'hABCDFFFE, 16'h0003, 1'b1, 1'b1, 1'b0, n);
        cmp("smul latency", 64'(n), 64'(18));
        cmp("smul prod", 64'(prod), 64'h00000000FFFFFFFA);
        cmp("smul v", 64'(v), 64'(0));
        run_op(32'h0000FFFE, 16'h0003, 1'b1, 1'b1, 1'b1, n);
        cmp("smul cen toggle latency", 64'(n), 64'(36));
        cmp("smul cen toggle prod", 64'(prod), 64'h00000000FFFFFFFA);
        run_op(32'h0000FFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, n);
        cmp("umul prod", 64'(prod), 64'h00000000FFFE0001);
`else
        @(posedge clk); #1;
        op0 = 32'h0000FFFE; op1 = 16'h0003; mode = 1'b1; sign = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp("mul disabled busy", 64'(busy), 64'(0));
        cmp("mul disabled prod", 64'(prod), 64'(0));
        mode = 1'b0;
`endif

        // Start during busy with new operands: result must still be 100000/300.
        @(posedge clk); #1;
        op0 = 32'h000186A0; op1 = 16'h012C; mode = 1'b0; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        op0 = 32'h00000010; op1 = 16'h0002; sign = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        cmp("busy start done seen", 64'(done), 64'(1));
        chk_div("busy start ignored", 16'h014D, 16'h0064, 1'b0, 1'b0);

        // Reset at cycle 5 of a divide.
        @(posedge clk); #1;
        op0 = 32'h000186A0; op1 = 16'h012C; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        cmp("abort busy", 64'(busy), 64'(0));
        cmp("abort done", 64'(done), 64'(0));
        chk_div("abort", 16'h0000, 16'h0000, 1'b0, 1'b0);
        cmp("abort prod", 64'(prod), 64'(0));

        run_op(32'h000186A0, 16'h012C, 1'b0, 1'b0, 1'b0, n);
        cmp("post-reset latency", 64'(n), 64'(18));
        chk_div("post-reset", 16'h014D, 16'h0064, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/jt900h_muldiv.md
JT900H_MULDIV -- requirements
Module: jt900h_muldiv

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning the operand width; legal values are 8, 16 and 32.
REQ-002 The block SHALL have the following ports, listed as name, direction, width, meaning:
- clk, input, 1: single clock.
- rst, input, 1: reset; synchronous, active-low.
- cen, input, 1: clock enable; all state advances only when cen=1.
- start, input, 1: operation request.
- mode, input, 1: 0 = divide, 1 = multiply.
- sign, input, 1: 1 = two's-complement operands.
- op0, input, 2W: dividend, or multiplicand in op0[W-1:0].
- op1, input, W: divisor or multiplier.
- busy, output, 1: operation in progress.
- done, output, 1: one-cen-cycle completion pulse.
- quot, output, W: quotient.
- rem, output, W: remainder.
- prod, output, 2W: product.
- v, output, 1: overflow flag.
- dz, output, 1: divide-by-zero flag.

Function
REQ-003 The block SHALL implement states IDLE, RUN, FIX and END; state SHALL change only on clk edges with cen=1.
REQ-004 In IDLE, start=1 with cen=1 SHALL latch op0, op1, mode and sign, and SHALL enter RUN; busy SHALL rise on the next edge.
REQ-005 start SHALL be ignored while busy=1; the latched operands SHALL NOT change until done.
REQ-006 RUN SHALL perform exactly W iterations of one bit each, counted by a counter of $clog2(W)+1 bits.
- Divide: restoring division on operand magnitudes.
- Multiply: shift-and-add on operand magnitudes.
REQ-007 FIX SHALL apply sign correction and SHALL compute v; END SHALL assert done for one cen cycle, drop busy and return to IDLE.
REQ-008 Total latency SHALL be W+2 cen cycles from the start edge to the done edge, for either mode.
REQ-009 Signed division SHALL truncate toward zero; rem SHALL take the sign of the dividend, and quot SHALL be negative when the operand signs differ.
REQ-010 v SHALL be 1 in each of the following cases:
- unsigned division, when op0[2W-1:W] >= op1;
- signed division, when the true quotient lies outside [-2^(W-1), 2^(W-1)-1];
- never in multiply mode.
REQ-011 When v=1 or dz=1, the block SHALL force quot={W{1}} and rem=op0[W-1:0].
REQ-012 For division with op1=0, the block SHALL set dz=1 and v=1, SHALL skip RUN and FIX, and done SHALL occur 2 cen cycles after start.
REQ-013 prod SHALL be the exact 2W-bit product; signed mode SHALL treat op0[W-1:0] and op1 as signed, and op0[2W-1:W] SHALL be ignored.
REQ-014 quot, rem, prod, v and dz SHALL hold their values from done until the next accepted start.
REQ-015 Edges with cen=0 SHALL freeze all state and outputs; done SHALL stay high until the next cen=1 edge.
REQ-016 A start sampled together with done=1 SHALL be ignored; a new operation requires IDLE.

Reset
REQ-017 While rst=0 on a clk edge, independent of cen, the block SHALL go to IDLE and clear busy, done, quot, rem, prod, v, dz and the iteration counter.
REQ-018 Reset mid-operation SHALL abort without asserting done; the first start after rst returns to 1 SHALL be accepted normally.

Configuration
REQ-019 With macro JT900H_MULDIV_MUL_EN defined, multiply mode SHALL behave as specified above.
REQ-020 Without JT900H_MULDIV_MUL_EN:
- start with mode=1 SHALL be ignored, and busy SHALL stay 0;
- prod SHALL be tied to 0;
- the multiply datapath SHALL be absent from the design;
- divide behaviour SHALL be unchanged.

Verification
REQ-021 The bench SHALL cover the following scenarios, all at W=16 with cen=1 unless stated:
- Unsigned divide 0x000186A0/0x012C: quot=0x014D, rem=0x0064, v=0, dz=0, done exactly 18 cycles after start.
- Signed divide 0xFFFFFFF9/0x0002: quot=0xFFFD, rem=0xFFFF, v=0.
- Divide 0x00001234/0x0000: dz=1, v=1, quot=0xFFFF, rem=0x1234, done 2 cycles after start.
- Unsigned 0x00010000/0x0001 gives v=1; signed 0x00008000/0x0001 gives v=1, quot=0xFFFF, rem=0x8000.
- Signed multiply 0xFFFE*0x0003: prod=0xFFFFFFFA, done 18 cycles after start; repeat with cen toggling 1/0, done after 36 clocks.
- Reset and ignored start: rst=0 at cycle 5 of a divide leaves busy=0, done never pulses and outputs are 0; a start during busy leaves the results unchanged.
